vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration helpers for the raster timing generator.
// Defaults describe 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package vga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_CNT_W    = 10;
   localparam int unsigned DEF_FRAME_W  = 8;

   // Full period of one axis: active, front porch, sync, back porch.
   function automatic int unsigned axis_total(input int unsigned active, fp, sync, bp);
      return active + fp + sync + bp;
   endfunction

   // Bits needed to hold any value in 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 32'd1 : int'($clog2(max_val + 1));
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the generator (master) and the pixel pipeline (slave).
interface vga_timing_gen_if #(
   parameter int unsigned CNT_W   = 10,
   parameter int unsigned FRAME_W = 8
);
   logic               ena;
   logic [CNT_W-1:0]   hpos;
   logic [CNT_W-1:0]   vpos;
   logic               hsync;
   logic               vsync;
   logic               display_on;
   logic               pix_en;
   logic               line_start;
   logic               frame_start;
   logic [FRAME_W-1:0] frame_cnt;

   modport master (
      input  ena,
      output hpos, vpos, hsync, vsync, display_on, pix_en,
             line_start, frame_start, frame_cnt
   );

   modport slave (
      output ena,
      input  hpos, vpos, hsync, vsync, display_on, pix_en,
             line_start, frame_start, frame_cnt
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered active/sync flags decoded
// from the next position, so flags and pos always change on the same edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BP     = 48,
   parameter bit          POL    = 1'b0,
   parameter int unsigned W      = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         advance,
   output logic [W-1:0] pos,
   output logic         wrap,
   output logic         active,
   output logic         sync
);

   localparam int unsigned  TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC - 1);

   logic         at_last;
   logic [W-1:0] pos_nxt;

   assign at_last = (pos == LAST);
   // Combinational so the next axis steps on the very edge this one wraps.
   assign wrap    = advance && at_last;

   always_comb begin
      // NOTE: default assignment first so every path drives pos_nxt and no latch is inferred.
      pos_nxt = pos;
      if (advance) begin
         pos_nxt = at_last ? '0 : pos + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      if (!rst_n) begin
         pos    <= LAST;
         active <= 1'b0;
         sync   <= ~POL;
      end else begin
         pos    <= pos_nxt;
         active <= (pos_nxt < ACT_END);
         sync   <= (pos_nxt >= SYNC_BEG && pos_nxt <= SYNC_END) ? POL : ~POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-clock divider, horizontal and
// vertical axis counters, line/frame strobes and a wrapping frame counter.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CLK_DIV  = 1,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned FRAME_W  = DEF_FRAME_W
) (
   input  logic             clk,
   input  logic             rst_n,
   vga_timing_gen_if.master tim
);

   localparam int unsigned      H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned      V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned      DIV_W    = cnt_width(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (cnt_width(H_TOTAL - 1) > CNT_W || cnt_width(V_TOTAL - 1) > CNT_W) begin : g_cnt_w_check
      $error("vga_timing_gen: CNT_W=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
             CNT_W, H_TOTAL - 1, V_TOTAL - 1);
   end

   if (CLK_DIV < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_param_check
      $error("vga_timing_gen: CLK_DIV, H_SYNC and V_SYNC must all be >= 1");
   end

   logic [DIV_W-1:0]   div_q;
   logic               div_tc;
   logic               pix_en;
   logic [CNT_W-1:0]   h_pos;
   logic [CNT_W-1:0]   v_pos;
   logic               h_wrap;
   logic               v_wrap;
   logic               h_active;
   logic               v_active;
   logic               h_sync;
   logic               v_sync;
   logic               line_q;
   logic               frame_q;
   logic [FRAME_W-1:0] frame_cnt_q;

   assign div_tc = (div_q == DIV_LAST);
   // Gated by rst_n so the strobe is quiet while the design is held in reset.
   assign pix_en = rst_n && tim.ena && div_tc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else if (tim.ena) begin
         div_q <= div_tc ? '0 : div_q + 1'b1;
      end
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL),
      .W      (CNT_W)
   ) u_h_axis (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (pix_en),
      .pos     (h_pos),
      .wrap    (h_wrap),
      .active  (h_active),
      .sync    (h_sync)
   );

   // The vertical axis steps once per line, so vsync covers whole lines.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL),
      .W      (CNT_W)
   ) u_v_axis (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (h_wrap),
      .pos     (v_pos),
      .wrap    (v_wrap),
      .active  (v_active),
      .sync    (v_sync)
   );

   // Strobes are captured on the wrap edge, so they coincide with (0,y) and (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q      <= 1'b0;
         frame_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         line_q  <= h_wrap;
         frame_q <= v_wrap;
         if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end

   assign tim.hpos        = h_pos;
   assign tim.vpos        = v_pos;
   assign tim.hsync       = h_sync;
   assign tim.vsync       = v_sync;
   assign tim.display_on  = h_active && v_active;
   assign tim.pix_en      = pix_en;
   assign tim.line_start  = line_q && tim.ena;
   assign tim.frame_start = frame_q && tim.ena;
   assign tim.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default mode, divided clock with
// active-high hsync, tiny mode for frame wrap) checked through a cycle-keyed scoreboard.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   typedef enum int {F_HPOS, F_VPOS, F_HS, F_VS, F_DE, F_PIX, F_LS, F_FS, F_FC} field_e;

   typedef struct {
      int     dut;
      int     at;
      field_e f;
      int     val;
      string  name;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   logic rst_c = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) ia ();
   vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) ib ();
   vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(8)) ic ();

   vga_timing_gen u_a (.clk(clk), .rst_n(rst_a), .tim(ia));

   vga_timing_gen #(.HS_POL(1'b1), .CLK_DIV(2)) u_b (.clk(clk), .rst_n(rst_b), .tim(ib));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CNT_W(4), .FRAME_W(8)
   ) u_c (.clk(clk), .rst_n(rst_c), .tim(ic));

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] sample(input int dut, input field_e f);
      logic [31:0] v0, v1, v2;
      v0 = '0; v1 = '0; v2 = '0;
      case (f)
         F_HPOS: begin v0 = 32'(ia.hpos);        v1 = 32'(ib.hpos);        v2 = 32'(ic.hpos);        end
         F_VPOS: begin v0 = 32'(ia.vpos);        v1 = 32'(ib.vpos);        v2 = 32'(ic.vpos);        end
         F_HS:   begin v0 = 32'(ia.hsync);       v1 = 32'(ib.hsync);       v2 = 32'(ic.hsync);       end
         F_VS:   begin v0 = 32'(ia.vsync);       v1 = 32'(ib.vsync);       v2 = 32'(ic.vsync);       end
         F_DE:   begin v0 = 32'(ia.display_on);  v1 = 32'(ib.display_on);  v2 = 32'(ic.display_on);  end
         F_PIX:  begin v0 = 32'(ia.pix_en);      v1 = 32'(ib.pix_en);      v2 = 32'(ic.pix_en);      end
         F_LS:   begin v0 = 32'(ia.line_start);  v1 = 32'(ib.line_start);  v2 = 32'(ic.line_start);  end
         F_FS:   begin v0 = 32'(ia.frame_start); v1 = 32'(ib.frame_start); v2 = 32'(ic.frame_start); end
         F_FC:   begin v0 = 32'(ia.frame_cnt);   v1 = 32'(ib.frame_cnt);   v2 = 32'(ic.frame_cnt);   end
         default: ;
      endcase
      case (dut)
         0:       return v0;
         1:       return v1;
         default: return v2;
      endcase
   endfunction

   task automatic push(input int dut, input int at, input field_e f, input int val, input string tag);
      exp_t e;
      e.dut  = dut;
      e.at   = at;
      e.f    = f;
      e.val  = val;
      e.name = $sformatf("%s.%s", tag, f.name());
      sb.push_back(e);
   endtask

   task automatic push_rst(input int dut, input int at, input int hl, input int vl,
                           input int hs_idle, input string tag);
      push(dut, at, F_HPOS, hl, tag);
      push(dut, at, F_VPOS, vl, tag);
      push(dut, at, F_DE, 0, tag);
      push(dut, at, F_HS, hs_idle, tag);
      push(dut, at, F_VS, 1, tag);
      push(dut, at, F_LS, 0, tag);
      push(dut, at, F_FS, 0, tag);
      push(dut, at, F_FC, 0, tag);
      push(dut, at, F_PIX, 0, tag);
   endtask

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            check(sb[i].name, sample(sb[i].dut, sb[i].f), sb[i].val);
            sb.delete(i);
         end
      end
   end

   // Default 640x480 mode: reset, first line, ena freeze, async reset.
   task automatic run_a();
      int b, n_de, n_hs, n_ls, hs_lo, hs_hi;
      wait_neg();
      push_rst(0, cyc + 1, 799, 524, 1, "A_rst");
      wait_neg();
      rst_a = 1'b1;
      b = cyc + 1;
      push(0, b, F_HPOS, 0, "A_first");  push(0, b, F_VPOS, 0, "A_first");
      push(0, b, F_DE, 1, "A_first");    push(0, b, F_LS, 1, "A_first");
      push(0, b, F_FS, 1, "A_first");    push(0, b, F_FC, 1, "A_first");
      push(0, b, F_HS, 1, "A_first");    push(0, b, F_VS, 1, "A_first");
      push(0, b, F_PIX, 1, "A_first");
      push(0, b + 1, F_HPOS, 1, "A_next"); push(0, b + 1, F_LS, 0, "A_next");
      push(0, b + 1, F_FS, 0, "A_next");   push(0, b + 1, F_FC, 1, "A_next");
      push(0, b + 639, F_DE, 1, "A_h639");
      push(0, b + 640, F_DE, 0, "A_h640"); push(0, b + 640, F_HPOS, 640, "A_h640");
      push(0, b + 655, F_HS, 1, "A_h655"); push(0, b + 656, F_HS, 0, "A_h656");
      push(0, b + 751, F_HS, 0, "A_h751"); push(0, b + 752, F_HS, 1, "A_h752");
      push(0, b + 799, F_HPOS, 799, "A_h799"); push(0, b + 799, F_VPOS, 0, "A_h799");
      push(0, b + 800, F_HPOS, 0, "A_line1"); push(0, b + 800, F_VPOS, 1, "A_line1");
      push(0, b + 800, F_LS, 1, "A_line1");   push(0, b + 800, F_FS, 0, "A_line1");
      push(0, b + 800, F_DE, 1, "A_line1");   push(0, b + 800, F_FC, 1, "A_line1");
      for (int k = 1; k <= 37; k++) begin
         push(0, b + 900 + k, F_HPOS, 100, "A_frz");
         push(0, b + 900 + k, F_PIX, 0, "A_frz");
         push(0, b + 900 + k, F_LS, 0, "A_frz");
      end
      push(0, b + 920, F_VPOS, 1, "A_frz"); push(0, b + 920, F_HS, 1, "A_frz");
      push(0, b + 920, F_DE, 1, "A_frz");   push(0, b + 920, F_FC, 1, "A_frz");
      push(0, b + 938, F_HPOS, 101, "A_resume"); push(0, b + 938, F_PIX, 1, "A_resume");
      push(0, b + 999, F_HPOS, 162, "A_prerst"); push(0, b + 999, F_VPOS, 1, "A_prerst");
      push(0, b + 999, F_FC, 1, "A_prerst");

      n_de = 0; n_hs = 0; n_ls = 0; hs_lo = 9999; hs_hi = -1;
      repeat (800) begin
         wait_neg();
         if (ia.display_on) n_de++;
         if (ia.line_start) n_ls++;
         if (!ia.hsync) begin
            n_hs++;
            if (int'(ia.hpos) < hs_lo) hs_lo = int'(ia.hpos);
            if (int'(ia.hpos) > hs_hi) hs_hi = int'(ia.hpos);
         end
      end
      check("A_line_de_count", n_de, 640);
      check("A_line_hs_count", n_hs, 96);
      check("A_line_hs_first", hs_lo, 656);
      check("A_line_hs_last", hs_hi, 751);
      check("A_line_ls_count", n_ls, 1);

      while (cyc < b + 900) wait_neg();
      ia.ena = 1'b0;
      while (cyc < b + 937) wait_neg();
      ia.ena = 1'b1;
      while (cyc < b + 999) wait_neg();
      @(posedge clk);
      #2;
      rst_a = 1'b0;
      push_rst(0, cyc, 799, 524, 1, "A_async");
      wait_neg();
      wait_neg();
      push_rst(0, cyc + 1, 799, 524, 1, "A_hold");
      wait_neg();
      rst_a = 1'b1;
      b = cyc + 1;
      push(0, b, F_HPOS, 0, "A_restart"); push(0, b, F_VPOS, 0, "A_restart");
      push(0, b, F_LS, 1, "A_restart");   push(0, b, F_FS, 1, "A_restart");
      push(0, b, F_FC, 1, "A_restart");   push(0, b, F_DE, 1, "A_restart");
      push(0, b + 1, F_HPOS, 1, "A_restart1"); push(0, b + 1, F_FS, 0, "A_restart1");
      while (cyc < b + 3) wait_neg();
   endtask

   // CLK_DIV=2, HS_POL=1: one pixel every two clocks, hsync active high.
   task automatic run_b();
      int r, b, n_hs, n_pix, n_ls, n_de;
      wait_neg();
      push_rst(1, cyc + 1, 799, 524, 0, "B_rst");
      wait_neg();
      rst_b = 1'b1;
      r = cyc;
      push(1, r + 1, F_HPOS, 799, "B_div"); push(1, r + 1, F_PIX, 1, "B_div");
      push(1, r + 1, F_LS, 0, "B_div");
      b = r + 2;
      push(1, b, F_HPOS, 0, "B_first"); push(1, b, F_VPOS, 0, "B_first");
      push(1, b, F_LS, 1, "B_first");   push(1, b, F_FS, 1, "B_first");
      push(1, b, F_FC, 1, "B_first");   push(1, b, F_PIX, 0, "B_first");
      push(1, b, F_HS, 0, "B_first");   push(1, b, F_DE, 1, "B_first");
      push(1, b + 1, F_HPOS, 0, "B_hold"); push(1, b + 1, F_LS, 0, "B_hold");
      push(1, b + 1, F_FS, 0, "B_hold");   push(1, b + 1, F_PIX, 1, "B_hold");
      push(1, b + 2, F_HPOS, 1, "B_step"); push(1, b + 2, F_PIX, 0, "B_step");
      push(1, b + 1311, F_HS, 0, "B_h655"); push(1, b + 1311, F_HPOS, 655, "B_h655");
      push(1, b + 1312, F_HS, 1, "B_h656"); push(1, b + 1312, F_HPOS, 656, "B_h656");
      push(1, b + 1503, F_HS, 1, "B_h751"); push(1, b + 1503, F_HPOS, 751, "B_h751");
      push(1, b + 1504, F_HS, 0, "B_h752"); push(1, b + 1504, F_HPOS, 752, "B_h752");
      push(1, b + 1599, F_HPOS, 799, "B_h799"); push(1, b + 1599, F_VPOS, 0, "B_h799");
      push(1, b + 1600, F_HPOS, 0, "B_line1"); push(1, b + 1600, F_VPOS, 1, "B_line1");
      push(1, b + 1600, F_LS, 1, "B_line1");   push(1, b + 1600, F_FS, 0, "B_line1");
      push(1, b + 1601, F_LS, 0, "B_line1w");  push(1, b + 1601, F_HPOS, 0, "B_line1w");

      wait_neg();
      n_hs = 0; n_pix = 0; n_ls = 0; n_de = 0;
      repeat (1600) begin
         wait_neg();
         if (ib.hsync) n_hs++;
         if (ib.pix_en) n_pix++;
         if (ib.line_start) n_ls++;
         if (ib.display_on) n_de++;
      end
      check("B_line_hs_count", n_hs, 192);
      check("B_line_pix_count", n_pix, 800);
      check("B_line_ls_count", n_ls, 1);
      check("B_line_de_count", n_de, 1280);
      while (cyc < b + 1602) wait_neg();
   endtask

   // Tiny 14x8 mode: vsync placement, per-frame strobes, frame_cnt wrap.
   task automatic run_c();
      int b, f, n_fs, n_ls, n_vs, n_de, n_hs;
      wait_neg();
      push_rst(2, cyc + 1, 13, 7, 1, "C_rst");
      wait_neg();
      rst_c = 1'b1;
      b = cyc + 1;
      push(2, b, F_HPOS, 0, "C_first"); push(2, b, F_VPOS, 0, "C_first");
      push(2, b, F_FS, 1, "C_first");   push(2, b, F_FC, 1, "C_first");
      push(2, b, F_LS, 1, "C_first");
      f = b + 112;
      push(2, f, F_FS, 1, "C_f1");        push(2, f, F_FC, 2, "C_f1");
      push(2, f + 9, F_HS, 1, "C_h9");    push(2, f + 10, F_HS, 0, "C_h10");
      push(2, f + 12, F_HS, 0, "C_h12");  push(2, f + 13, F_HS, 1, "C_h13");
      push(2, f + 49, F_DE, 1, "C_v3h7"); push(2, f + 50, F_DE, 0, "C_v3h8");
      push(2, f + 56, F_DE, 0, "C_v4h0"); push(2, f + 56, F_LS, 1, "C_v4h0");
      push(2, f + 69, F_VS, 1, "C_v4h13");
      push(2, f + 70, F_VS, 0, "C_v5h0"); push(2, f + 70, F_VPOS, 5, "C_v5h0");
      push(2, f + 97, F_VS, 0, "C_v6h13");
      push(2, f + 98, F_VS, 1, "C_v7h0"); push(2, f + 98, F_VPOS, 7, "C_v7h0");
      push(2, b + 112 * 254, F_FC, 255, "C_f254"); push(2, b + 112 * 254, F_FS, 1, "C_f254");
      push(2, b + 112 * 254 + 111, F_FC, 255, "C_f254end");
      push(2, b + 112 * 254 + 111, F_HPOS, 13, "C_f254end");
      push(2, b + 112 * 254 + 111, F_VPOS, 7, "C_f254end");
      push(2, b + 112 * 254 + 111, F_FS, 0, "C_f254end");
      push(2, b + 112 * 255, F_FC, 0, "C_f255");   push(2, b + 112 * 255, F_FS, 1, "C_f255");
      push(2, b + 112 * 255, F_HPOS, 0, "C_f255"); push(2, b + 112 * 255, F_VPOS, 0, "C_f255");
      push(2, b + 112 * 256, F_FC, 1, "C_f256");   push(2, b + 112 * 256, F_FS, 1, "C_f256");

      while (cyc < b + 111) wait_neg();
      n_fs = 0; n_ls = 0; n_vs = 0; n_de = 0; n_hs = 0;
      repeat (112) begin
         wait_neg();
         if (ic.frame_start) n_fs++;
         if (ic.line_start) n_ls++;
         if (!ic.vsync) n_vs++;
         if (ic.display_on) n_de++;
         if (!ic.hsync) n_hs++;
      end
      check("C_frame_fs_count", n_fs, 1);
      check("C_frame_ls_count", n_ls, 8);
      check("C_frame_vs_count", n_vs, 28);
      check("C_frame_de_count", n_de, 32);
      check("C_frame_hs_count", n_hs, 24);
      while (cyc < b + 112 * 256 + 1) wait_neg();
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: bench did not finish within time limit (cyc %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      ia.ena = 1'b1;
      ib.ena = 1'b1;
      ic.ena = 1'b1;
      fork
         run_a();
         run_b();
         run_c();
      join
      repeat (3) wait_neg();
      foreach (sb[i]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: never compared (due cyc %0d, now %0d)", sb[i].name, sb[i].at, cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
